// File: rtl/pipelined_crossbar_pkg.sv
// Shared types and helpers for the pipelined crossbar: flit type, skid states, one-hot check.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package VR_pkg;

  localparam int unsigned FLIT_WIDTH = `FLIT_DATA_WIDTH;
  localparam int unsigned SEL_MAX_W  = 32;

  typedef logic [FLIT_WIDTH-1:0] flit_t;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_TWO
  } skid_state_e;

  // True when exactly one bit of the (zero-extended) select is set.
  function automatic logic onehot_chk(input logic [SEL_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - SEL_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/pipelined_crossbar_if.sv
// Crossbar bus bundle; master = traffic source/sink side, slave = the switch.
// out_flit_cnt exists only when XBAR_STATS_EN is defined.
interface pipelined_crossbar_if #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned NUM_OUT    = 4,
  parameter int unsigned DATA_WIDTH = `FLIT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic [NUM_IN-1:0][DATA_WIDTH-1:0]  in_data;
  logic [NUM_IN-1:0][NUM_OUT-1:0]     in_sel;
  logic [NUM_IN-1:0]                  in_valid;
  logic [NUM_IN-1:0]                  in_ready;
  logic [NUM_OUT-1:0][DATA_WIDTH-1:0] out_data;
  logic [NUM_OUT-1:0]                 out_valid;
  logic [NUM_OUT-1:0]                 out_ready;
  logic                               clr_err;
  logic                               err_conflict;
  logic                               err_sel;
`ifdef XBAR_STATS_EN
  logic [NUM_OUT-1:0][CNT_WIDTH-1:0]  out_flit_cnt;
`else
  logic                               unused_cnt_cfg;
  assign unused_cnt_cfg = (CNT_WIDTH != 0);
`endif

  modport master (
    output in_data, in_sel, in_valid, out_ready, clr_err,
    input  in_ready, out_data, out_valid, err_conflict, err_sel
`ifdef XBAR_STATS_EN
    , input out_flit_cnt
`endif
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready, clr_err,
    output in_ready, out_data, out_valid, err_conflict, err_sel
`ifdef XBAR_STATS_EN
    , output out_flit_cnt
`endif
  );
endinterface

// File: rtl/pipelined_crossbar_out_skid.sv
// Per-output 2-entry skid buffer; head register always drives out_data/out_valid.
module xbar_out_skid
  import VR_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = `FLIT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  skid_rdy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  pop
);
  skid_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic                  valid_q, rdy_q;

  assign pop       = valid_q & out_ready;
  assign out_valid = valid_q;
  assign out_data  = head_q;
  assign skid_rdy  = rdy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= (state_d != SKID_EMPTY);
      rdy_q   <= (state_d != SKID_TWO);
    end
  end

  // Push is never offered in TWO because skid_rdy is low there.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          state_d = SKID_ONE;
          head_d  = push_data;
        end
      end
      SKID_ONE: begin
        if (push && !pop) begin
          state_d = SKID_TWO;
          tail_d  = push_data;
        end else if (pop && !push) begin
          state_d = SKID_EMPTY;
        end else if (push && pop) begin
          head_d  = push_data;
        end
      end
      SKID_TWO: begin
        if (pop) begin
          state_d = SKID_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end
endmodule

// File: rtl/pipelined_crossbar.sv
// Registered NUM_IN x NUM_OUT flit switch: fixed-priority arbitration per output, skid-buffered
// outputs, sticky error flags; per-output pop counters when XBAR_STATS_EN is defined.
module pipelined_crossbar
  import VR_pkg::*;
#(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned NUM_OUT    = 4,
  parameter int unsigned DATA_WIDTH = `FLIT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  pipelined_crossbar_if.slave bus
);
  logic [NUM_IN-1:0]                  sel_ok;
  logic [NUM_OUT-1:0][NUM_IN-1:0]     req;
  logic [NUM_OUT-1:0]                 push, skid_rdy, pop, conflict, out_valid_w;
  logic [NUM_OUT-1:0][DATA_WIDTH-1:0] push_data, out_data_w;
  logic [NUM_OUT-1:0]                 lower_tgt;
  logic [NUM_IN-1:0]                  in_ready_c;
  logic                               err_conflict_q, err_sel_q;

  // Decode selects into a per-output request matrix; bad selects never request.
  always_comb begin
    sel_ok = '0;
    req    = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      sel_ok[j] = onehot_chk(SEL_MAX_W'(bus.in_sel[j]));
      for (int o = 0; o < NUM_OUT; o++) begin
        req[o][j] = bus.in_valid[j] & sel_ok[j] & bus.in_sel[j][o];
      end
    end
  end

  // Lowest-index requester wins each output.
  always_comb begin
    push_data = '0;
    push      = '0;
    conflict  = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int j = NUM_IN - 1; j >= 0; j--) begin
        if (req[o][j]) push_data[o] = bus.in_data[j];
      end
      push[o]     = (|req[o]) & skid_rdy[o];
      conflict[o] = ((req[o] & (req[o] - NUM_IN'(1))) != '0);
    end
  end

  // Input accepted if its output has room and no lower-index valid input targets it.
  always_comb begin
    lower_tgt  = '0;
    in_ready_c = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      in_ready_c[j] = rst_n & (~sel_ok[j] |
                      ((|(bus.in_sel[j] & skid_rdy)) & ~(|(bus.in_sel[j] & lower_tgt))));
      if (bus.in_valid[j] && sel_ok[j]) lower_tgt = lower_tgt | bus.in_sel[j];
    end
  end

  assign bus.in_ready = in_ready_c;

  // Sticky flags; a new event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_conflict_q <= 1'b0;
      err_sel_q      <= 1'b0;
    end else begin
      if (|conflict)          err_conflict_q <= 1'b1;
      else if (bus.clr_err)   err_conflict_q <= 1'b0;
      if (|(bus.in_valid & ~sel_ok)) err_sel_q <= 1'b1;
      else if (bus.clr_err)          err_sel_q <= 1'b0;
    end
  end

  assign bus.err_conflict = err_conflict_q;
  assign bus.err_sel      = err_sel_q;

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
    xbar_out_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[o]),
      .push_data (push_data[o]),
      .skid_rdy  (skid_rdy[o]),
      .out_valid (out_valid_w[o]),
      .out_data  (out_data_w[o]),
      .out_ready (bus.out_ready[o]),
      .pop       (pop[o])
    );
  end

  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_data_w;

`ifdef XBAR_STATS_EN
  logic [NUM_OUT-1:0][CNT_WIDTH-1:0] cnt_q;

  // Saturating delivered-flit counters; not affected by clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int o = 0; o < NUM_OUT; o++) begin
        if (pop[o] && (cnt_q[o] != '1)) cnt_q[o] <= cnt_q[o] + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.out_flit_cnt = cnt_q;
`else
  logic unused_stats;
  assign unused_stats = (|pop) | (CNT_WIDTH != 0);
`endif
endmodule
